// File: rtl/alu_muldiv_ctrl.sv
// ALU control decoder plus an iterative multiply/divide unit (shift-add multiply,
// restoring divide) with a valid/ready request and result handshake.
module alu_muldiv_ctrl #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        ALUOp,
  input  logic [6:0]        funct7,
  input  logic [2:0]        funct3,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              is_muldiv,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result,
  output logic              busy
);

  localparam logic [3:0] C_AND = 4'b0000, C_OR  = 4'b0001, C_ADD  = 4'b0010, C_XOR = 4'b0011;
  localparam logic [3:0] C_SLL = 4'b0100, C_SRL = 4'b0101, C_SRA  = 4'b1000, C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111, C_SLTU = 4'b1001;
  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t             state_r;
  logic               in_ready_r, busy_r, out_valid_r;
  logic [XLEN-1:0]    result_r, mag_b_r;
  logic [2*XLEN-1:0]  prod_r;
  logic [CW-1:0]      cnt_r;
  logic [2:0]         f3_r;
  logic               neg_q_r, neg_r_r;

  logic [3:0]         ctrl_s;
  logic [3:0]         base_s;
  logic               is_muldiv_s, accept_s;
  logic               neg_a_s, neg_b_s, div0_s, ovf_s;
  logic [XLEN-1:0]    mag_a_s, mag_b_s, special_s;
  logic [XLEN:0]      mul_sum_s, trial_s;
  logic [XLEN-1:0]    sub_s;
  logic               ge_s;
  logic [2*XLEN-1:0]  mul_next_s, div_next_s, neg_prod_s;
  logic [XLEN-1:0]    fix_s;

  assign is_muldiv_s = (ALUOp == 2'b10) && (funct7 == 7'b0000001);
  assign accept_s    = in_valid && in_ready_r && is_muldiv_s;

  // Base R/I-type funct3 table shared by both instruction classes
  always_comb begin
    base_s = C_ADD;
    case (funct3)
      3'b000:  base_s = C_ADD;
      3'b001:  base_s = C_SLL;
      3'b010:  base_s = C_SLT;
      3'b011:  base_s = C_SLTU;
      3'b100:  base_s = C_XOR;
      3'b101:  base_s = C_SRL;
      3'b110:  base_s = C_OR;
      3'b111:  base_s = C_AND;
      default: base_s = C_ADD;
    endcase
  end

  // ALU select decode; anything not explicitly decoded falls back to ADD
  always_comb begin
    ctrl_s = C_ADD;
    case (ALUOp)
      2'b00: ctrl_s = C_ADD;
      2'b01: ctrl_s = C_SUB;
      2'b10: begin
        if (funct7 == 7'b0000000) begin
          ctrl_s = base_s;
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000)      ctrl_s = C_SUB;
          else if (funct3 == 3'b101) ctrl_s = C_SRA;
          else                       ctrl_s = C_ADD;
        end else begin
          ctrl_s = C_ADD;
        end
      end
      2'b11: begin
        if (funct3 == 3'b101 && funct7[5]) ctrl_s = C_SRA;
        else                               ctrl_s = base_s;
      end
      default: ctrl_s = C_ADD;
    endcase
  end

  assign alu_ctrl  = CTRL_W'(ctrl_s);
  assign is_muldiv = is_muldiv_s;

  // Operand magnitudes, sign flags and the divide special cases at accept time
  always_comb begin
    if (funct3[2]) begin
      neg_a_s = ~funct3[0] & op_a[XLEN-1];
      neg_b_s = ~funct3[0] & op_b[XLEN-1];
    end else begin
      neg_a_s = (funct3 == 3'b001 || funct3 == 3'b010) & op_a[XLEN-1];
      neg_b_s = (funct3 == 3'b001) & op_b[XLEN-1];
    end
    mag_a_s = neg_a_s ? -op_a : op_a;
    mag_b_s = neg_b_s ? -op_b : op_b;
    div0_s  = funct3[2] && (op_b == '0);
    ovf_s   = funct3[2] && ~funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    if (div0_s) special_s = funct3[1] ? op_a : '1;
    else        special_s = funct3[1] ? '0 : op_a;
  end

  // One multiply or divide step; the product register holds {rem, quotient} when dividing
  always_comb begin
    mul_sum_s  = {1'b0, prod_r[2*XLEN-1:XLEN]} + (prod_r[0] ? {1'b0, mag_b_r} : {(XLEN+1){1'b0}});
    mul_next_s = {mul_sum_s, prod_r[XLEN-1:1]};
    trial_s    = {prod_r[2*XLEN-1:XLEN], prod_r[XLEN-1]};
    ge_s       = trial_s >= {1'b0, mag_b_r};
    sub_s      = trial_s[XLEN-1:0] - mag_b_r;
    div_next_s = {(ge_s ? sub_s : trial_s[XLEN-1:0]), prod_r[XLEN-2:0], ge_s};
  end

  // Final sign correction and half/quotient/remainder selection
  always_comb begin
    neg_prod_s = -prod_r;
    fix_s      = '0;
    if (f3_r[2]) begin
      if (f3_r[1]) fix_s = neg_r_r ? -prod_r[2*XLEN-1:XLEN] : prod_r[2*XLEN-1:XLEN];
      else         fix_s = neg_q_r ? -prod_r[XLEN-1:0] : prod_r[XLEN-1:0];
    end else begin
      if (f3_r[1:0] == 2'b00) fix_s = neg_q_r ? neg_prod_s[XLEN-1:0] : prod_r[XLEN-1:0];
      else                    fix_s = neg_q_r ? neg_prod_s[2*XLEN-1:XLEN] : prod_r[2*XLEN-1:XLEN];
    end
  end

  // Mul/div sequencer with registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      result_r    <= '0;
      cnt_r       <= '0;
      prod_r      <= '0;
      mag_b_r     <= '0;
      f3_r        <= 3'b000;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            f3_r       <= funct3;
            prod_r     <= {{XLEN{1'b0}}, mag_a_s};
            mag_b_r    <= mag_b_s;
            neg_q_r    <= neg_a_s ^ neg_b_s;
            neg_r_r    <= neg_a_s;
            cnt_r      <= '0;
            if (div0_s || ovf_s) begin
              result_r    <= special_s;
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end else begin
              state_r <= funct3[2] ? DIV : MUL;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        MUL, DIV: begin
          prod_r <= (state_r == MUL) ? mul_next_s : div_next_s;
          if (cnt_r == CW'(XLEN-1)) begin
            cnt_r   <= '0;
            state_r <= FIX;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        FIX: begin
          result_r    <= fix_s;
          out_valid_r <= 1'b1;
          state_r     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
          out_valid_r <= 1'b0;
          cnt_r       <= '0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Randomised bench for alu_muldiv_ctrl: a cycle-level behavioural model of the
// decoder and the mul/div handshake is compared against the DUT every cycle.
module tb_alu_muldiv_ctrl;
  localparam int XLEN = 32;
  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_XOR = 4'b0011;
  localparam logic [3:0] C_SLL = 4'b0100, C_SRL = 4'b0101, C_SRA = 4'b1000, C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111, C_SLTU = 4'b1001;

  logic clk, reset;
  logic [1:0] ALUOp;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [3:0] alu_ctrl;
  logic is_muldiv, in_valid, in_ready, out_valid, out_ready, busy;
  logic [XLEN-1:0] op_a, op_b, result;

  int n_checks = 0;
  int n_fail = 0;

  alu_muldiv_ctrl #(.XLEN(XLEN), .CTRL_W(4)) dut (
    .clk(clk), .reset(reset), .ALUOp(ALUOp), .funct7(funct7), .funct3(funct3),
    .alu_ctrl(alu_ctrl), .is_muldiv(is_muldiv), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
    logic [3:0] tbl [8];
    tbl = '{C_ADD, C_SLL, C_SLT, C_SLTU, C_XOR, C_SRL, C_OR, C_AND};
    if (op == 2'b00) return C_ADD;
    if (op == 2'b01) return C_SUB;
    if (op == 2'b10 && f7 == 7'h20) return (f3 == 3'd0) ? C_SUB : (f3 == 3'd5) ? C_SRA : C_ADD;
    if (op == 2'b10 && f7 != 7'h00) return C_ADD;
    if (op == 2'b11 && f3 == 3'd5 && f7[5]) return C_SRA;
    return tbl[f3];
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return is_special(f3, a, b) ? 1 : XLEN + 2;
  endfunction

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub_s;
    logic [63:0] ua, ub, p;
    logic signed [31:0] qa, qb, qr;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ub_s = ub;
    qa = a;
    qb = b;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub_s; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (is_special(f3, a, b)) return a;
        qr = qa / qb; return qr;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (is_special(f3, a, b)) return 32'd0;
        qr = qa % qb; return qr;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Behavioural model: idle / counting down to result / holding result
  logic m_busy, m_ov;
  logic [31:0] m_res;
  int m_rem;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_ov = 1'b0; m_res = 32'd0; m_rem = 0;
    end else if (m_ov) begin
      if (out_ready) begin m_busy = 1'b0; m_ov = 1'b0; end
    end else if (m_busy) begin
      m_rem--;
      if (m_rem == 0) m_ov = 1'b1;
    end else if (in_valid && ALUOp == 2'b10 && funct7 == 7'h01) begin
      m_busy = 1'b1;
      m_res  = ref_res(funct3, op_a, op_b);
      m_rem  = ref_lat(funct3, op_a, op_b) - 1;
      m_ov   = (m_rem == 0);
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    chk("alu_ctrl", alu_ctrl, ref_ctrl(ALUOp, funct7, funct3));
    chk("is_muldiv", is_muldiv, (ALUOp == 2'b10 && funct7 == 7'h01));
    chk("in_ready", in_ready, !m_busy);
    chk("busy", busy, m_busy);
    chk("out_valid", out_valid, m_ov);
    if (m_ov) chk("result", result, m_res);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  task automatic drain;
    int g;
    in_valid = 1'b0;
    out_ready = 1'b1;
    g = 0;
    while (!in_ready && g < 100) begin tick; g++; end
    chk("drain_idle", in_ready, 1'b1);
    out_ready = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit lit, input logic [31:0] er, input int el);
    int lat;
    logic [31:0] exp_r;
    int exp_l;
    exp_r = lit ? er : ref_res(f3, a, b);
    exp_l = lit ? el : ref_lat(f3, a, b);
    tick;
    chk("pre_ready", in_ready, 1'b1);
    ALUOp = 2'b10; funct7 = 7'h01; funct3 = f3; op_a = a; op_b = b;
    in_valid = 1'b1; out_ready = 1'b0;
    tick;
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin tick; lat++; end
    chk("latency", lat, exp_l);
    chk("op_result", result, exp_r);
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_ready", in_ready, 1'b0);
      chk("hold_result", result, exp_r);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("post_valid", out_valid, 1'b0);
    chk("post_ready", in_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ALUOp = 2'b00; funct7 = 7'h00; funct3 = 3'd0;
    in_valid = 1'b0; out_ready = 1'b0; op_a = 32'd0; op_b = 32'd0;
    repeat (3) tick;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, 32'd0);
    reset = 1'b0;
    tick;

    ALUOp = 2'b10; funct7 = 7'h20; funct3 = 3'd5; #1;
    chk("dec_sra", alu_ctrl, C_SRA);
    chk("dec_sra_md", is_muldiv, 1'b0);
    ALUOp = 2'b01; funct7 = 7'h55; funct3 = 3'd3; #1;
    chk("dec_branch", alu_ctrl, C_SUB);
    ALUOp = 2'b11; funct7 = 7'h00; funct3 = 3'd7; #1;
    chk("dec_andi", alu_ctrl, C_AND);

    // Random decode sweep with incidental mul/div traffic
    for (int i = 0; i < 300; i++) begin
      ALUOp = 2'($urandom);
      case ($urandom_range(0, 3))
        0: funct7 = 7'h00;
        1: funct7 = 7'h20;
        2: funct7 = 7'h01;
        default: funct7 = 7'($urandom);
      endcase
      funct3 = 3'($urandom);
      op_a = pick(); op_b = pick();
      in_valid = 1'($urandom);
      out_ready = ($urandom_range(0, 3) == 0);
      tick;
    end
    drain;

    do_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 0, 1'b1, 32'hFFFF_FFFF, 34);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 32'h8000_0000, 1);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b1, 32'h0000_0000, 1);
    do_op(3'd5, 32'h1234_5678, 32'h0000_0000, 0, 1'b1, 32'hFFFF_FFFF, 1);
    do_op(3'd7, 32'h0000_0007, 32'h0000_0000, 0, 1'b1, 32'h0000_0007, 1);
    do_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5, 1'b1, 32'hFFFF_FFFF, 34);
    do_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b1, 32'hFFFF_FFFD, 34);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 32'hFFFF_FFFE, 34);

    // Reset in the tenth MUL cycle discards the op
    tick;
    ALUOp = 2'b10; funct7 = 7'h01; funct3 = 3'd0; op_a = 32'd77; op_b = 32'd3;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (9) tick;
    #2 reset = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    tick;
    reset = 1'b0;
    do_op(3'd0, 32'h0000_1234, 32'h0000_0010, 0, 1'b1, 32'h0001_2340, 34);

    for (int i = 0; i < 60; i++) begin
      do_op(3'($urandom), pick(), pick(), $urandom_range(0, 3), 1'b0, 32'd0, 0);
    end
    drain;
    repeat (2) tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
